// File: rtl/bulls_cows_auto_guesser_if.sv
// Guess/feedback exchange between the automatic guesser (master) and the scorer (slave).
interface bulls_cows_auto_guesser_if;
  logic [15:0] guess;
  logic        guess_valid;
  logic        guess_ready;
  logic        fb_valid;
  logic [3:0]  fb_a;
  logic [3:0]  fb_b;

  modport master (
    output guess, guess_valid,
    input  guess_ready, fb_valid, fb_a, fb_b
  );

  modport slave (
    input  guess, guess_valid,
    output guess_ready, fb_valid, fb_a, fb_b
  );
endinterface

// File: rtl/bulls_cows_auto_guesser.sv
// 1A2B automatic guesser: proposes the lowest distinct-digit BCD candidate consistent with history.
// Optional GUESSER_STATS_EN adds a saturating count of SEARCH cycles per game.
module bulls_cows_auto_guesser #(
  parameter int unsigned MAX_GUESSES = 10
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  bulls_cows_auto_guesser_if.master   bus,
  output logic                        busy,
  output logic                        solved,
  output logic                        fail,
  output logic [3:0]                  guess_num
`ifdef GUESSER_STATS_EN
  , output logic [15:0]               search_cycles
`endif
);

  localparam int unsigned CNT_W = 4;
  localparam logic [15:0] FIRST_CAND = 16'h0123;

  typedef enum logic [2:0] {IDLE, SEARCH, ISSUE, WAIT_FB, SOLVED, FAIL} state_t;

  state_t            state, next_state;
  logic [15:0]       cand;
  logic [15:0]       guess_q;
  logic              guess_valid_q;
  logic [CNT_W-1:0]  idx;
  logic [CNT_W-1:0]  hist_cnt;
  logic [15:0]       hist_g [MAX_GUESSES];
  logic [3:0]        hist_a [MAX_GUESSES];
  logic [3:0]        hist_b [MAX_GUESSES];

  logic              distinct_c, found_c, reject_c, fb_bad_c, last_slot_c;
  logic [16:0]       inc_c;
  logic [7:0]        score_c;

  // BCD increment with per-nibble carry; bit 16 flags the wrap past 9999.
  function automatic logic [16:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (r[i*4 +: 4] == 4'd9) r[i*4 +: 4] = 4'd0;
        else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return {c, r};
  endfunction

  // Returns {A, B} of candidate c scored against guess g.
  function automatic logic [7:0] score(input logic [15:0] g, input logic [15:0] c);
    logic [3:0] a, b;
    a = 4'd0;
    b = 4'd0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (g[i*4 +: 4] == c[j*4 +: 4]) begin
          if (i == j) a = a + 4'd1;
          else        b = b + 4'd1;
        end
    return {a, b};
  endfunction

  function automatic logic all_distinct(input logic [15:0] v);
    logic d;
    d = 1'b1;
    for (int i = 0; i < 4; i++)
      for (int j = i + 1; j < 4; j++)
        if (v[i*4 +: 4] == v[j*4 +: 4]) d = 1'b0;
    return d;
  endfunction

  always_comb begin
    next_state  = state;
    distinct_c  = all_distinct(cand);
    inc_c       = bcd_inc(cand);
    score_c     = score(hist_g[idx], cand);
    found_c     = distinct_c && (idx == hist_cnt);
    reject_c    = !distinct_c ||
                  (idx != hist_cnt && score_c != {hist_a[idx], hist_b[idx]});
    fb_bad_c    = ((5'(bus.fb_a) + 5'(bus.fb_b)) > 5'd4) ||
                  (bus.fb_a == 4'd3 && bus.fb_b == 4'd1);
    last_slot_c = (5'(hist_cnt) + 5'd1) == 5'(MAX_GUESSES);
    case (state)
      IDLE, SOLVED, FAIL: if (start) next_state = SEARCH;
      SEARCH: begin
        if (reject_c && inc_c[16]) next_state = FAIL;
        else if (found_c)          next_state = ISSUE;
      end
      ISSUE: if (bus.guess_ready) next_state = WAIT_FB;
      WAIT_FB: begin
        if (bus.fb_valid) begin
          if (fb_bad_c)               next_state = FAIL;
          else if (bus.fb_a == 4'd4)  next_state = SOLVED;
          else if (last_slot_c)       next_state = FAIL;
          else                        next_state = SEARCH;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // State register; status outputs are registered decodes of the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      busy          <= 1'b0;
      solved        <= 1'b0;
      fail          <= 1'b0;
      guess_valid_q <= 1'b0;
    end else begin
      state         <= next_state;
      busy          <= (next_state == SEARCH) || (next_state == ISSUE) || (next_state == WAIT_FB);
      solved        <= (next_state == SOLVED);
      fail          <= (next_state == FAIL);
      guess_valid_q <= (next_state == ISSUE);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cand      <= FIRST_CAND;
      idx       <= '0;
      hist_cnt  <= '0;
      guess_num <= '0;
      guess_q   <= '0;
    end else begin
      case (state)
        IDLE, SOLVED, FAIL: if (start) begin
          cand      <= FIRST_CAND;
          idx       <= '0;
          hist_cnt  <= '0;
          guess_num <= '0;
        end
        SEARCH: begin
          if (reject_c) begin
            cand <= inc_c[15:0];
            idx  <= '0;
          end else if (found_c) begin
            guess_q <= cand;
          end else begin
            idx <= CNT_W'(idx + 4'd1);
          end
        end
        ISSUE: if (bus.guess_ready) guess_num <= guess_num + 4'd1;
        WAIT_FB: if (bus.fb_valid) begin
          hist_cnt <= hist_cnt + 4'd1;
          cand     <= inc_c[15:0];
          idx      <= '0;
        end
        default: ;
      endcase
    end
  end

  // History storage needs no reset: entries above hist_cnt are never read.
  always_ff @(posedge clk) begin
    if (state == ISSUE && bus.guess_ready) hist_g[hist_cnt] <= cand;
    if (state == WAIT_FB && bus.fb_valid) begin
      hist_a[hist_cnt] <= bus.fb_a;
      hist_b[hist_cnt] <= bus.fb_b;
    end
  end

`ifdef GUESSER_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n)                                                search_cycles <= '0;
    else if ((state == IDLE || state == SOLVED || state == FAIL) && start)
                                                               search_cycles <= '0;
    else if (state == SEARCH && search_cycles != 16'hFFFF)     search_cycles <= search_cycles + 16'd1;
  end
`endif

  assign bus.guess       = guess_q;
  assign bus.guess_valid = guess_valid_q;

endmodule

// File: tb/tb_bulls_cows_auto_guesser.sv
// Directed self-checking bench for bulls_cows_auto_guesser (checks search_cycles when GUESSER_STATS_EN).
module tb_bulls_cows_auto_guesser;
  logic       clk;
  logic       rst_n;
  logic       start;
  logic       busy, solved, fail;
  logic [3:0] guess_num;
`ifdef GUESSER_STATS_EN
  logic [15:0] search_cycles;
  logic [15:0] sc_snap;
`endif
  int n_cmp = 0;
  int n_err = 0;

  bulls_cows_auto_guesser_if bus ();

  bulls_cows_auto_guesser #(.MAX_GUESSES(10)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .bus       (bus),
    .busy      (busy),
    .solved    (solved),
    .fail      (fail),
    .guess_num (guess_num)
`ifdef GUESSER_STATS_EN
    , .search_cycles (search_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int max_cycles);
    for (int i = 0; i < max_cycles && bus.guess_valid !== 1'b1; i++) tick();
    chk(tag, 32'(bus.guess_valid), 32'd1);
  endtask

  task automatic handshake();
    bus.guess_ready = 1'b1;
    tick();
    bus.guess_ready = 1'b0;
  endtask

  task automatic send_fb(input logic [3:0] a, input logic [3:0] b);
    bus.fb_valid = 1'b1;
    bus.fb_a     = a;
    bus.fb_b     = b;
    tick();
    bus.fb_valid = 1'b0;
    bus.fb_a     = 4'd0;
    bus.fb_b     = 4'd0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_guess"}, 32'(bus.guess), 32'h0);
    chk({tag, "_valid"}, 32'(bus.guess_valid), 32'd0);
    chk({tag, "_busy"},  32'(busy), 32'd0);
    chk({tag, "_solved"}, 32'(solved), 32'd0);
    chk({tag, "_fail"},  32'(fail), 32'd0);
    chk({tag, "_num"},   32'(guess_num), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    bus.guess_ready = 1'b0;
    bus.fb_valid = 1'b0;
    bus.fb_a = 4'd0;
    bus.fb_b = 4'd0;
    tick();
    tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // stray feedback while idle
    send_fb(4'd4, 4'd0);
    chk("idle_stray_busy", 32'(busy), 32'd0);
    chk("idle_stray_solved", 32'(solved), 32'd0);

    // 1: secret 0123
    do_start();
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_valid_early", 32'(bus.guess_valid), 32'd0);
    tick();
    chk("t1_valid_2cyc", 32'(bus.guess_valid), 32'd1);
    chk("t1_guess", 32'(bus.guess), 32'h0123);
    handshake();
    chk("t1_num_hs", 32'(guess_num), 32'd1);
    chk("t1_valid_drop", 32'(bus.guess_valid), 32'd0);
    send_fb(4'd4, 4'd0);
    chk("t1_solved", 32'(solved), 32'd1);
    chk("t1_num", 32'(guess_num), 32'd1);
    chk("t1_busy_end", 32'(busy), 32'd0);
`ifdef GUESSER_STATS_EN
    chk("t1_search_cycles", 32'(search_cycles), 32'd1);
`endif

    // 2: secret 4567
    do_start();
    wait_valid("t2_valid1", 10);
    chk("t2_guess1", 32'(bus.guess), 32'h0123);
    handshake();
    send_fb(4'd0, 4'd0);
    wait_valid("t2_valid2", 20000);
    chk("t2_guess2", 32'(bus.guess), 32'h4567);
    handshake();
    chk("t2_num_hs", 32'(guess_num), 32'd2);
    send_fb(4'd4, 4'd0);
    chk("t2_solved", 32'(solved), 32'd1);
    chk("t2_num", 32'(guess_num), 32'd2);

    // 3: contradictory history exhausts the search
    do_start();
    wait_valid("t3_valid1", 10);
    handshake();
    send_fb(4'd0, 4'd0);
    wait_valid("t3_valid2", 20000);
    chk("t3_guess2", 32'(bus.guess), 32'h4567);
    handshake();
    send_fb(4'd0, 4'd0);
    for (int i = 0; i < 40000 && fail !== 1'b1; i++) tick();
    chk("t3_fail", 32'(fail), 32'd1);
    chk("t3_valid", 32'(bus.guess_valid), 32'd0);
    chk("t3_num", 32'(guess_num), 32'd2);
    chk("t3_busy", 32'(busy), 32'd0);
`ifdef GUESSER_STATS_EN
    sc_snap = search_cycles;
    n_cmp++;
    assert (sc_snap != 16'd0) else begin
      n_err++;
      $error("FAIL t3_sc_nonzero: observed %0h expected nonzero", sc_snap);
    end
    repeat (5) tick();
    chk("t3_sc_frozen", 32'(search_cycles), 32'(sc_snap));
`endif

    // 4: backpressure, plus start while busy is ignored
    do_start();
    wait_valid("t4_valid", 10);
    for (int i = 0; i < 20; i++) begin
      if (i == 10) start = 1'b1;
      tick();
      start = 1'b0;
      chk("t4_hold_valid", 32'(bus.guess_valid), 32'd1);
      chk("t4_hold_guess", 32'(bus.guess), 32'h0123);
    end
    chk("t4_num_before", 32'(guess_num), 32'd0);
    bus.guess_ready = 1'b1;
    tick();
    chk("t4_num_after", 32'(guess_num), 32'd1);
    tick();
    bus.guess_ready = 1'b0;
    chk("t4_one_hs_num", 32'(guess_num), 32'd1);
    chk("t4_one_hs_valid", 32'(bus.guess_valid), 32'd0);

    // 5: stray feedback in ISSUE, then illegal 3A1B
    send_fb(4'd0, 4'd0);
    wait_valid("t5_valid", 20000);
    chk("t5_guess", 32'(bus.guess), 32'h4567);
    send_fb(4'd4, 4'd0);
    chk("t5_stray_valid", 32'(bus.guess_valid), 32'd1);
    chk("t5_stray_guess", 32'(bus.guess), 32'h4567);
    chk("t5_stray_solved", 32'(solved), 32'd0);
    handshake();
    chk("t5_num", 32'(guess_num), 32'd2);
    send_fb(4'd3, 4'd1);
    chk("t5_fail", 32'(fail), 32'd1);
    chk("t5_busy", 32'(busy), 32'd0);

    // 6: reset in the middle of SEARCH
    do_start();
    chk("t6_in_search", 32'(busy), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk_all_zero("t6_reset");
    do_start();
    tick();
    chk("t6_valid", 32'(bus.guess_valid), 32'd1);
    chk("t6_guess", 32'(bus.guess), 32'h0123);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
